ps2_keycode_source: RTL and testbench
=====================================

# ps2_keycode_source

Producer side of the 8-bit `keycode` bus that the game state machine consumes. It receives PS/2 Set-2 scancodes from the keyboard port and handles make, break and extended prefixes. It translates the supported keys to HID usage codes. It presents a level `keycode` that is held while the key is down, plus a one-cycle `key_press` strobe for each new press.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of idle `Clk` cycles inside a frame before a partial frame is abandoned (1 ms at 50 MHz).
- `Clk` input, 1 bit: system clock.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `ps2_clk` input, 1 bit: raw PS/2 clock, asynchronous to `Clk`.
- `ps2_data` input, 1 bit: raw PS/2 data, asynchronous to `Clk`.
- `keycode` output, 8 bits: HID code of the most recently pressed supported key that is still held; 0x00 when none.
- `key_press` output, 1 bit: one-cycle pulse when `keycode` changes to a new non-zero value.
- `frame_error` output, 1 bit: one-cycle pulse on a parity error, a bad start or stop bit, or a timeout.

## Operation
- Synchronisation:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A falling edge of the synchronised `ps2_clk` samples the synchronised `ps2_data`.
- Frame format: 11 bits, in this order:
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity bit (the 8 data bits plus parity contain an odd number of ones);
  - stop bit = 1.
- Frame receive states:
  - IDLE: a sampled 0 moves to DATA. A sampled 1 stays in IDLE with no error.
  - DATA: 8 samples, shifted in LSB first.
  - PARITY: 1 sample.
  - STOP: 1 sample. A valid frame delivers the byte to the decoder. An invalid parity or stop bit pulses `frame_error` and discards the byte. Both cases return to IDLE.
- Timeout:
  - The idle counter runs in any state other than IDLE and clears on each falling edge.
  - When it reaches `TIMEOUT_CYCLES`, the receiver pulses `frame_error` and returns to IDLE.
  - The decoder also returns to MAKE.
- Decoder states:
  - MAKE: byte 0xE0 goes to EXT; 0xF0 goes to BRK; any other byte is a plain make.
  - EXT: 0xF0 goes to EXT_BRK; any other byte is an extended make, then return to MAKE.
  - BRK: the byte is a plain break, then return to MAKE.
  - EXT_BRK: the byte is an extended break, then return to MAKE.
  - 0xAA, 0xFA and 0xEE in MAKE are ignored.
- Translation, plain codes:
  - 1D→1A (W), 1C→04 (A), 1B→16 (S), 23→07 (D);
  - 5A→28 (Enter), 76→29 (Esc), 29→2C (Space).
- Translation, extended (E0-prefixed) codes:
  - 75→52 (Up), 6B→50 (Left), 72→51 (Down), 74→4F (Right).
  - Extended 5A maps to 28 (keypad Enter).
- Unmapped codes update no output, but still consume the prefix state.
- Make of a mapped code:
  - If the HID code differs from the current `keycode`, load it into `keycode` and pulse `key_press`.
  - If it equals the current `keycode` (typematic repeat), there is no pulse and no change.
- Break of a mapped code:
  - If the HID code equals `keycode`, `keycode` becomes 0x00.
  - Otherwise nothing changes, so a second held key's release does not clear the first.

## Timing
- Reset: `keycode`=0x00, `key_press`=0, `frame_error`=0, receiver in IDLE, decoder in MAKE, counters cleared.
- Reset applies asynchronously at any point, including mid-frame or mid-prefix. No pulse is produced on reset exit.
- Falling-edge detection lags the pin by 3 `Clk` cycles (2 for sync, 1 for the edge register).
- `keycode` and `key_press` update in the `Clk` cycle after the cycle in which the stop bit is sampled.
- `key_press` coincides with the first cycle of the new `keycode` value.
- `frame_error` is asserted in the cycle after the failing sample, or in the cycle after the timeout count is reached.
- A byte that completes while the timeout count is also reached counts as complete; the timeout does not fire.
- The PS/2 bit period is ≥60 µs, so the block needs no backpressure and has no output buffering.

## Structure
- Package `ps2_pkg`, shared with the game state machine:
  - HID constants `KEY_W`, `KEY_A`, `KEY_S`, `KEY_D`, `KEY_ENTER`, `KEY_ESC`, `KEY_SPACE` and the four arrow constants;
  - prefix constants `PS2_EXT`=0xE0 and `PS2_BRK`=0xF0;
  - decoder state enum;
  - translation function `ps2_to_hid(ext, code)`, which returns 0x00 for unmapped codes.
- Sub-module `ps2_frame_rx` holds the synchroniser, edge detect, frame receive states and timeout. Its outputs are `byte_valid`, `byte_data[7:0]` and `frame_error`.
- The top level instantiates `ps2_frame_rx` and contains the prefix decoder, the translation and the output registers.

## Test plan
- Frames 1D, then F0 1D → `keycode`=1A with `key_press` high for one cycle, then `keycode`=0x00 after the second stop bit.
- Frames E0 75, then E0 F0 75 → `keycode`=52, then 0x00; no change is caused by the E0 byte alone.
- Press 1D, press 1C, release 1D, release 1C → `keycode` sequence 1A, 04, 04, 00 with exactly two `key_press` pulses.
- Frame 1D sent three times (typematic) → `keycode`=1A with exactly one `key_press` pulse.
- Frame 1D with a flipped parity bit → one `frame_error` pulse and `keycode` stays 0x00. Then 0 start plus 4 data bits, followed by TIMEOUT_CYCLES+1 idle cycles → one `frame_error` pulse, and the next valid 1C frame yields `keycode`=04.
- `Reset` asserted after 6 bits of frame 1D → outputs are 0 immediately, and the next valid 23 frame yields `keycode`=07.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 Set-2 prefixes, HID key constants, decoder states and translation
package ps2_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_ACK  = 8'hFA;
    localparam logic [7:0] PS2_ECHO = 8'hEE;

    typedef enum logic [1:0] {DEC_MAKE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Returns 0x00 for any scancode the game does not use.
    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = 8'h00;
        if (ext) begin
            case (code)
                8'h75:   hid = KEY_UP;
                8'h6B:   hid = KEY_LEFT;
                8'h72:   hid = KEY_DOWN;
                8'h74:   hid = KEY_RIGHT;
                8'h5A:   hid = KEY_ENTER;
                default: hid = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1D:   hid = KEY_W;
                8'h1C:   hid = KEY_A;
                8'h1B:   hid = KEY_S;
                8'h23:   hid = KEY_D;
                8'h5A:   hid = KEY_ENTER;
                8'h76:   hid = KEY_ESC;
                8'h29:   hid = KEY_SPACE;
                default: hid = 8'h00;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line synchroniser, 11-bit frame receiver and inter-bit timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error,
    output logic       timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rx_state_e        state_q;
    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             dat_s1_q, dat_s2_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             valid_q, err_q, to_q;
    logic             fall;

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign byte_valid  = valid_q;
    assign byte_data   = shift_q;
    assign frame_error = err_q;
    assign timeout_o   = to_q;

    // Synchronisers reset low so a line held low through reset cannot fake a falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RX_IDLE;
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            idle_cnt_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data_i;
            dat_s2_q   <= dat_s1_q;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            if (fall) begin
                idle_cnt_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= RX_STOP;
                    end
                    default: begin
                        if (dat_s2_q && (^{shift_q, par_q})) valid_q <= 1'b1;
                        else                                err_q   <= 1'b1;
                        state_q <= RX_IDLE;
                    end
                endcase
            end else if (state_q != RX_IDLE) begin
                if (idle_cnt_q == CNT_LAST) begin
                    err_q      <= 1'b1;
                    to_q       <= 1'b1;
                    idle_cnt_q <= '0;
                    state_q    <= RX_IDLE;
                end else begin
                    idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_source.sv
// rtl/ps2_keycode_source.sv - PS/2 prefix decoder and held-key HID keycode register
module ps2_keycode_source
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_press,
    output logic       frame_error
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_timeout;
    dec_state_e dec_q;
    logic [7:0] keycode_q;
    logic       key_press_q;
    logic [7:0] hid;
    logic       is_prefix, is_ignored, make_evt, brk_evt;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (frame_error),
        .timeout_o   (rx_timeout)
    );

    always_comb begin
        hid        = ps2_to_hid(dec_q == DEC_EXT || dec_q == DEC_EXT_BRK, byte_data);
        is_prefix  = (byte_data == PS2_EXT) || (byte_data == PS2_BRK);
        is_ignored = (byte_data == PS2_BAT) || (byte_data == PS2_ACK) || (byte_data == PS2_ECHO);
        make_evt   = byte_valid && ((dec_q == DEC_MAKE && !is_prefix && !is_ignored) ||
                                    (dec_q == DEC_EXT && byte_data != PS2_BRK));
        brk_evt    = byte_valid && (dec_q == DEC_BRK || dec_q == DEC_EXT_BRK);
    end

    assign keycode   = keycode_q;
    assign key_press = key_press_q;

    // Releasing a key other than the current one leaves keycode alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dec_q       <= DEC_MAKE;
            keycode_q   <= 8'h00;
            key_press_q <= 1'b0;
        end else begin
            key_press_q <= 1'b0;
            if (rx_timeout) begin
                dec_q <= DEC_MAKE;
            end else if (byte_valid) begin
                case (dec_q)
                    DEC_MAKE: begin
                        if (byte_data == PS2_EXT)      dec_q <= DEC_EXT;
                        else if (byte_data == PS2_BRK) dec_q <= DEC_BRK;
                    end
                    DEC_EXT:  dec_q <= (byte_data == PS2_BRK) ? DEC_EXT_BRK : DEC_MAKE;
                    default:  dec_q <= DEC_MAKE;
                endcase
            end
            if (make_evt && hid != 8'h00 && hid != keycode_q) begin
                keycode_q   <= hid;
                key_press_q <= 1'b1;
            end else if (brk_evt && hid != 8'h00 && hid == keycode_q) begin
                keycode_q <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// tb/tb_ps2_keycode_source.sv - scoreboard bench for ps2_keycode_source
module tb_ps2_keycode_source;

    localparam int TO   = 100;
    localparam int HALF = 8;
    localparam logic [1:0] EV_PRESS = 2'd1;
    localparam logic [1:0] EV_REL   = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_press;
    logic       frame_error;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    logic [7:0] model_kc = 8'h00;
    logic [7:0] prev_kc = 8'h00;

    ps2_keycode_source #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keycode     (keycode),
        .key_press   (key_press),
        .frame_error (frame_error)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [9:0] obs);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(obs), 32'h3FF);
        else                   check(tag, 32'(obs), 32'(exp_q.pop_front()));
    endtask

    function automatic logic [7:0] tb_hid(input bit ext, input logic [7:0] c);
        if (ext) begin
            case (c)
                8'h75: return 8'h52;
                8'h6B: return 8'h50;
                8'h72: return 8'h51;
                8'h74: return 8'h4F;
                8'h5A: return 8'h28;
                default: return 8'h00;
            endcase
        end
        case (c)
            8'h1D: return 8'h1A;
            8'h1C: return 8'h04;
            8'h1B: return 8'h16;
            8'h23: return 8'h07;
            8'h5A: return 8'h28;
            8'h76: return 8'h29;
            8'h29: return 8'h2C;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge Clk) begin
        if (Reset) begin
            prev_kc <= 8'h00;
        end else begin
            if (frame_error) pop_check("ferr", {EV_ERR, 8'h00});
            if (key_press) begin
                pop_check("press", {EV_PRESS, keycode});
                check("press_edge", 32'(keycode != prev_kc), 32'd1);
            end else if (keycode != prev_kc) begin
                pop_check("release", {EV_REL, keycode});
            end
            prev_kc <= keycode;
        end
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge Clk);
            #3 ps2_clk = 1'b0;
            repeat (HALF) @(posedge Clk);
            #3 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flip);
        send_bits({1'b1, (~^code) ^ flip, code, 1'b0}, 11);
        repeat (20) @(posedge Clk);
    endtask

    task automatic make_key(input bit ext, input logic [7:0] code);
        logic [7:0] h;
        h = tb_hid(ext, code);
        if (h != 8'h00 && h != model_kc) begin
            exp_q.push_back({EV_PRESS, h});
            model_kc = h;
        end
        if (ext) send_frame(8'hE0, 1'b0);
        send_frame(code, 1'b0);
    endtask

    task automatic break_key(input bit ext, input logic [7:0] code);
        logic [7:0] h;
        h = tb_hid(ext, code);
        if (h != 8'h00 && h == model_kc) begin
            exp_q.push_back({EV_REL, 8'h00});
            model_kc = 8'h00;
        end
        if (ext) send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(code, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge Clk);
        repeat (5) @(posedge Clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic timeout_partial();
        exp_q.push_back({EV_ERR, 8'h00});
        send_bits({1'b1, 1'b0, 8'h1D, 1'b0}, 5);
        repeat (TO + 1) @(posedge Clk);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_keycode", 32'(keycode), 32'h00);
        check("rst_key_press", 32'(key_press), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        @(negedge Clk) Reset = 1'b0;
        repeat (10) @(posedge Clk);

        make_key(1'b0, 8'h1D);   drain("t1_press");
        check("t1_keycode", 32'(keycode), 32'h1A);
        break_key(1'b0, 8'h1D);  drain("t1_release");

        make_key(1'b1, 8'h75);   drain("t2_press");
        check("t2_keycode", 32'(keycode), 32'h52);
        break_key(1'b1, 8'h75);  drain("t2_release");

        make_key(1'b0, 8'h1D);
        make_key(1'b0, 8'h1C);
        break_key(1'b0, 8'h1D);
        check("t3_held", 32'(keycode), 32'h04);
        break_key(1'b0, 8'h1C);  drain("t3_seq");

        for (int i = 0; i < 3; i++) make_key(1'b0, 8'h1D);
        drain("t4_typematic");
        break_key(1'b0, 8'h1D);  drain("t4_release");

        send_frame(8'hAA, 1'b0);
        make_key(1'b0, 8'h15);
        make_key(1'b1, 8'h5A);   drain("ext_enter");
        check("ext_enter_kc", 32'(keycode), 32'h28);
        break_key(1'b1, 8'h5A);  drain("ext_enter_rel");

        exp_q.push_back({EV_ERR, 8'h00});
        send_frame(8'h1D, 1'b1); drain("t5_parity");
        check("t5_keycode", 32'(keycode), 32'h00);
        timeout_partial();       drain("t5_timeout");
        make_key(1'b0, 8'h1C);   drain("t5_after_to");
        check("t5_after_kc", 32'(keycode), 32'h04);
        break_key(1'b0, 8'h1C);  drain("t5_rel");

        send_frame(8'hE0, 1'b0);
        timeout_partial();       drain("to_prefix");
        make_key(1'b0, 8'h1D);   drain("to_prefix_make");
        break_key(1'b0, 8'h1D);  drain("to_prefix_rel");

        make_key(1'b0, 8'h1C);   drain("t6_pre");
        send_bits({1'b1, 1'b0, 8'h1D, 1'b0}, 6);
        #3 Reset = 1'b1;
        #1;
        check("t6_rst_kc", 32'(keycode), 32'h00);
        check("t6_rst_kp", 32'(key_press), 32'd0);
        check("t6_rst_fe", 32'(frame_error), 32'd0);
        model_kc = 8'h00;
        exp_q.delete();
        repeat (3) @(posedge Clk);
        ps2_data = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        repeat (10) @(posedge Clk);
        make_key(1'b0, 8'h23);   drain("t6_after");
        check("t6_keycode", 32'(keycode), 32'h07);

        repeat (20) @(posedge Clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
